// File: rtl/sa_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic-array phase sequencer.
// Used by sa_ctrl (optional weight reuse is selected with SA_CTRL_WREUSE_EN).
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } sa_state_t;

  function automatic int sa_cnt_w(input int rows, input int cols, input int cwidth);
    int lw;
    lw = $clog2(rows + cols);
    return (cwidth > lw) ? cwidth : lw;
  endfunction

  // Pipeline depth that must be flushed after the last ifm vector enters.
  function automatic int sa_drain_len(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

  function automatic bit sa_has_drain(input int rows, input int cols);
    return sa_drain_len(rows, cols) != 0;
  endfunction

endpackage

// File: rtl/phase_cnt.sv
// Loadable down-counter that times each sequencer phase; holds at zero.
// Async active-low reset to 0.
module phase_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sa_ctrl.sv
// Phase sequencer for the weight-stationary systolic array: CLR, WLOAD, STREAM, DRAIN, DONE.
// Define SA_CTRL_WREUSE_EN to add keep_w, which keeps resident weights and skips WLOAD.
module sa_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CWIDTH-1:0] k_len,
`ifdef SA_CTRL_WREUSE_EN
  input  logic              keep_w,
`endif
  output logic              busy,
  output logic              done,
  output logic              en_i,
  output logic              clr_i,
  output logic              en_w,
  output logic              clr_w,
  output logic              en_o,
  output logic              clr_o,
  output logic              wght_rd,
  output logic              ifm_rd
);

  localparam int CNT_W     = sa_cnt_w(ROWS, COLS, CWIDTH);
  localparam int DRAIN_LEN = sa_drain_len(ROWS, COLS);
  localparam bit HAS_DRAIN = sa_has_drain(ROWS, COLS);
  localparam logic [CNT_W-1:0] WLOAD_LAST = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = HAS_DRAIN ? CNT_W'(DRAIN_LEN - 1) : '0;

  sa_state_t         state;
  sa_state_t         state_nxt;
  logic [CWIDTH-1:0] k_len_q;
  logic [CNT_W-1:0]  k_last;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic              skip_w;
  logic              accept;

  // A start only counts when it is not overridden by a simultaneous abort.
  assign accept = (state == S_IDLE) && start && !abort;
  assign k_last = CNT_W'(k_len_q) - CNT_W'(1);

`ifdef SA_CTRL_WREUSE_EN
  logic keep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keep_q <= 1'b0;
    end else if (accept) begin
      keep_q <= keep_w;
    end
  end

  assign skip_w = keep_q;
`else
  assign skip_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k_len_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        k_len_q <= k_len;
      end
    end
  end

  phase_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .val  (cnt_val),
    .zero (cnt_zero)
  );

  // The counter is loaded with length-1 only on the edge that enters a timed phase.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    if (abort && state != S_IDLE && state != S_ABORT) begin
      state_nxt = S_ABORT;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state_nxt = S_CLR;
          end
        end
        S_CLR: begin
          if (k_len_q == '0) begin
            state_nxt = S_DONE;
          end else if (skip_w) begin
            state_nxt = S_STREAM;
            cnt_load  = 1'b1;
            cnt_val   = k_last;
          end else begin
            state_nxt = S_WLOAD;
            cnt_load  = 1'b1;
            cnt_val   = WLOAD_LAST;
          end
        end
        S_WLOAD: begin
          if (cnt_zero) begin
            state_nxt = S_STREAM;
            cnt_load  = 1'b1;
            cnt_val   = k_last;
          end
        end
        S_STREAM: begin
          if (cnt_zero) begin
            if (HAS_DRAIN) begin
              state_nxt = S_DRAIN;
              cnt_load  = 1'b1;
              cnt_val   = DRAIN_LAST;
            end else begin
              state_nxt = S_DONE;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_zero) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        S_ABORT: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != S_IDLE);
    done    = 1'b0;
    en_i    = 1'b0;
    clr_i   = 1'b0;
    en_w    = 1'b0;
    clr_w   = 1'b0;
    en_o    = 1'b0;
    clr_o   = 1'b0;
    wght_rd = 1'b0;
    ifm_rd  = 1'b0;
    case (state)
      S_CLR: begin
        clr_i = 1'b1;
        clr_w = !skip_w;
        clr_o = 1'b1;
      end
      S_ABORT: begin
        clr_i = 1'b1;
        clr_w = 1'b1;
        clr_o = 1'b1;
      end
      S_WLOAD: begin
        en_w    = 1'b1;
        wght_rd = 1'b1;
      end
      S_STREAM: begin
        en_i   = 1'b1;
        en_o   = 1'b1;
        ifm_rd = 1'b1;
      end
      S_DRAIN: begin
        en_i = 1'b1;
        en_o = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/sa_ctrl.md
# sa_ctrl

Phase sequencer for the weight-stationary systolic array built from the border and interior PEs. On a `start` pulse it clears the array, loads weights, streams `k_len` input vectors and then drains the pipeline. It drives the `en_*`/`clr_*` strobes of the corner PE, which the PEs forward through their registered `_d` outputs. It sits between the tile scheduler and the array, and also issues read strobes to the weight and ifm buffers.

## Interface
- `ROWS`, default 8: array height; sets weight-load cycles and drain depth.
- `COLS`, default 8: array width; sets drain depth.
- `CWIDTH`, default 16: width of `k_len`.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset. Asynchronous, active-low.
- `start  in  1`: begin one tile; sampled only in IDLE.
- `abort  in  1`: synchronous abandon; honoured in any non-IDLE state.
- `k_len  in  CWIDTH`: number of ifm vectors; captured with `start`.
- `busy  out  1`: high in every state except IDLE.
- `done  out  1`: one-cycle pulse at tile end; not asserted on abort.
- `en_i`, `clr_i`, `en_w`, `clr_w`, `en_o`, `clr_o  out  1 each`: to the corner PE.
- `wght_rd  out  1`: weight-buffer read strobe.
- `ifm_rd  out  1`: ifm-buffer read strobe.

## Operation
- FSM states: IDLE, CLR, WLOAD, STREAM, DRAIN, DONE.
- All outputs are decoded from the registered state only; there is no input-to-output combinational path.
- IDLE: all outputs 0. On `start`=1, capture `k_len` and go to CLR.
- CLR (1 cycle): `clr_i`=`clr_w`=`clr_o`=1. Next state is WLOAD, or DONE if the captured `k_len`=0.
- WLOAD (ROWS cycles): `en_w`=`wght_rd`=1.
- STREAM (k_len cycles): `en_i`=`en_o`=`ifm_rd`=1.
- DRAIN (ROWS+COLS-2 cycles): `en_i`=`en_o`=1, `ifm_rd`=0. The ifm datapath zero-pads while `ifm_rd`=0.
- DONE (1 cycle): `done`=1, then IDLE.
- Phase counter:
  - One down-counter, width max(CWIDTH, $clog2(ROWS+COLS)).
  - Loaded with phase length minus 1 on phase entry; the phase exits when the counter reads 0.
  - If ROWS+COLS-2 = 0, DRAIN is skipped (STREAM goes to DONE).
- `start` while `busy`: ignored; `k_len` is not re-captured.
- `abort` in a non-IDLE state:
  - Next state is CLR-abort: one cycle of `clr_*`=1 with `done`=0, then IDLE.
  - `abort` during that cycle has no further effect.
- `start` and `abort` high together in IDLE: `abort` wins and `start` is dropped.
- `rst_n` low at any time: state is IDLE, counter is 0, all outputs are 0 immediately, including mid-phase.

## Timing
- `start` sampled at edge t → CLR is visible in cycle t+1.
- Busy duration is 1 + ROWS + k_len + (ROWS+COLS-2) + 1 cycles; for k_len=0 it is 2 cycles.
- `done` is high in the last busy cycle. `busy` falls together with `done` on the following edge.
- Back-to-back operation: `start` held high during DONE is ignored. The earliest new CLR comes one cycle after IDLE is re-entered.
- Reset values: `busy`, `done`, all `en_*`/`clr_*`, `wght_rd` and `ifm_rd` are 0.

## Configuration
- Macro `SA_CTRL_WREUSE_EN`.
- Defined:
  - Adds input `keep_w` (1 bit), captured with `start`.
  - If the captured value is 1, CLR asserts only `clr_i`/`clr_o` (`clr_w`=0) and WLOAD is skipped: CLR → STREAM.
  - Busy duration shrinks by ROWS cycles.
- Undefined: no `keep_w` port; every tile clears and reloads weights.

## Structure
- Package `sa_ctrl_pkg` holds:
  - the state enum typedef `sa_state_t`;
  - the function `sa_cnt_w(ROWS, COLS, CWIDTH)` returning the counter width;
  - localparam-style helpers for the drain length.
- Sub-module `phase_cnt`: loadable down-counter with `load`, `val` and a `zero` flag, async active-low reset to 0.

## Test plan
- Reset mid-WLOAD: assert `rst_n`=0 in cycle 3 after `start` → all outputs 0 in that cycle; IDLE after release; a later `start` runs a full tile.
- ROWS=COLS=4, k_len=5, single `start`:
  - `busy` high for exactly 17 cycles;
  - `clr_*` for 1 cycle, then `en_w` for 4, then `ifm_rd` for 5, then `en_o` for 11 total;
  - `done` pulses in cycle 17.
- k_len=0: CLR then DONE; `busy` is 2 cycles; `en_w`, `en_i` and `en_o` never assert.
- `abort` in the 2nd STREAM cycle: next cycle has `clr_*`=1 and `done`=0; IDLE the cycle after; `done` never pulses.
- `start` re-pulsed during STREAM with a different `k_len`: ignored; tile length matches the first `k_len`.
- With `SA_CTRL_WREUSE_EN`, `keep_w`=1, ROWS=COLS=4, k_len=5: `busy` is 13 cycles; `clr_w` and `en_w` stay 0.
